// File: rtl/dense_pkg.sv
// Shared definitions for the dense-layer weight streaming path.
package dense_pkg;

  localparam int DENSE_WORD_SIZE = 32;
  localparam int DENSE_LENGTH    = 10;
  localparam int DENSE_ADR_SIZE  = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } dense_state_t;

endpackage

// File: rtl/dense_weight_addr_counter.sv
// Issue counter for the weight LUT. The counter is one bit wider than the
// address so that a full 2**ADR_SIZE pass can be represented. The address
// output is clamped to the last legal word once every word has been issued.
module dense_weight_addr_counter
  import dense_pkg::*;
#(
  parameter int ADR_SIZE    = DENSE_ADR_SIZE,
  parameter int LENGTH_SIZE = DENSE_LENGTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_inc,
  output logic [ADR_SIZE-1:0] o_adr,
  output logic                o_tc,
  output logic                o_is_last
);

  localparam logic [ADR_SIZE:0]   LEN      = (ADR_SIZE+1)'(LENGTH_SIZE);
  localparam logic [ADR_SIZE:0]   LAST_CNT = (ADR_SIZE+1)'(LENGTH_SIZE-1);
  localparam logic [ADR_SIZE-1:0] LAST_ADR = ADR_SIZE'(LENGTH_SIZE-1);

  logic [ADR_SIZE:0] r_fetchCnt;
  logic              w_tc;

  assign w_tc      = (r_fetchCnt == LEN);
  assign o_tc      = w_tc;
  assign o_is_last = (r_fetchCnt == LAST_CNT);
  assign o_adr     = w_tc ? LAST_ADR : r_fetchCnt[ADR_SIZE-1:0];

  // fetch counter: cleared on reset/clear, saturates at LENGTH_SIZE
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_fetchCnt <= '0;
    end else if (i_inc && !w_tc) begin
      r_fetchCnt <= r_fetchCnt + 1'b1;
    end
  end

endmodule

// File: rtl/dense_weight_streamer.sv
// Read-side master for the dense weight LUT: walks the LUT address range once
// per start, registers each word and hands it to the MAC on a valid/ready
// stream. The LUT itself lives in the parent.
module dense_weight_streamer
  import dense_pkg::*;
#(
  parameter int WORD_SIZE   = DENSE_WORD_SIZE,
  parameter int LENGTH_SIZE = DENSE_LENGTH,
  parameter int ADR_SIZE    = DENSE_ADR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [ADR_SIZE-1:0]  lutAdr,
  input  logic [WORD_SIZE-1:0] lutData,
  output logic [WORD_SIZE-1:0] outData,
  output logic [ADR_SIZE-1:0]  outIdx,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 outLast,
  output logic                 busy,
  output logic                 done
);

  dense_state_t r_state, w_next;

  logic [WORD_SIZE-1:0] r_outData;
  logic [ADR_SIZE-1:0]  r_outIdx;
  logic                 r_outValid;
  logic                 r_outLast;
  logic                 r_done;

  logic [ADR_SIZE-1:0]  w_adr;
  logic                 w_tc;
  logic                 w_isLast;
  logic                 w_inStream;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_lastAccept;
  logic                 w_clr;

  assign w_inStream   = (r_state == ST_STREAM);
  assign w_accept     = r_outValid && outReady;
  // abort suppresses any new load so the output slot empties next cycle
  assign w_load       = w_inStream && !abort && (!r_outValid || outReady) && !w_tc;
  assign w_lastAccept = w_inStream && w_accept && r_outLast;
  // the counter rests at zero while idle so a new pass always starts at word 0
  assign w_clr        = (r_state == ST_IDLE);

  dense_weight_addr_counter #(
    .ADR_SIZE    (ADR_SIZE),
    .LENGTH_SIZE (LENGTH_SIZE)
  ) u_addr_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_inc     (w_load),
    .o_adr     (w_adr),
    .o_tc      (w_tc),
    .o_is_last (w_isLast)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic: abort beats both start and completion
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start && !abort)          w_next = ST_STREAM;
      ST_STREAM: if (abort || w_lastAccept)    w_next = ST_IDLE;
      default:                                 w_next = ST_IDLE;
    endcase
  end

  // output slot: load a fresh word, drain on accept, or flush on abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outData  <= '0;
      r_outIdx   <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end else if (w_inStream && abort) begin
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end else if (w_load) begin
      r_outData  <= lutData;
      r_outIdx   <= w_adr;
      r_outLast  <= w_isLast;
      r_outValid <= 1'b1;
    end else if (w_accept) begin
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end
  end

  // completion pulse, withheld when the final accept coincides with abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_lastAccept && !abort;
    end
  end

  assign lutAdr   = w_adr;
  assign outData  = r_outData;
  assign outIdx   = r_outIdx;
  assign outValid = r_outValid;
  assign outLast  = r_outLast;
  assign busy     = w_inStream;
  assign done     = r_done;

endmodule

// File: tb/tb_dense_weight_streamer.sv
// Bench for dense_weight_streamer: a 10-word build and a full-range 16-word
// build, each fed by a behavioural LUT array.
module tb_dense_weight_streamer;

  localparam int W   = 32;
  localparam int A   = 4;
  localparam int L   = 10;
  localparam int L16 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, abort, outReady;
  logic [A-1:0] lutAdr, outIdx;
  logic [W-1:0] lutData, outData;
  logic         outValid, outLast, busy, done;

  logic         start16, abort16, outReady16;
  logic [A-1:0] lutAdr16, outIdx16;
  logic [W-1:0] lutData16, outData16;
  logic         outValid16, outLast16, busy16, done16;

  logic [W-1:0] lut10 [16];
  logic [W-1:0] lut16 [16];

  assign lutData   = lut10[lutAdr];
  assign lutData16 = lut16[lutAdr16];

  int checks = 0;
  int errors = 0;

  dense_weight_streamer #(.WORD_SIZE(W), .LENGTH_SIZE(L), .ADR_SIZE(A)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .lutAdr(lutAdr), .lutData(lutData), .outData(outData), .outIdx(outIdx),
    .outValid(outValid), .outReady(outReady), .outLast(outLast),
    .busy(busy), .done(done)
  );

  dense_weight_streamer #(.WORD_SIZE(W), .LENGTH_SIZE(L16), .ADR_SIZE(A)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort16),
    .lutAdr(lutAdr16), .lutData(lutData16), .outData(outData16), .outIdx(outIdx16),
    .outValid(outValid16), .outReady(outReady16), .outLast(outLast16),
    .busy(busy16), .done(done16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_adr"},   64'(lutAdr),   64'd0);
    chk({pfx, "_data"},  64'(outData),  64'd0);
    chk({pfx, "_idx"},   64'(outIdx),   64'd0);
    chk({pfx, "_vld"},   64'(outValid), 64'd0);
    chk({pfx, "_last"},  64'(outLast),  64'd0);
    chk({pfx, "_busy"},  64'(busy),     64'd0);
    chk({pfx, "_done"},  64'(done),     64'd0);
  endtask

  // Consume the rest of a pass starting at word `first`, checking every
  // accepted word against the LUT in order and the done pulse afterwards.
  task automatic drain(input int first, input int rdy_pct, input bit poke,
                       input bit tput, input bit chain);
    int acc = first;
    int n = 0;
    bit held = 1'b0;
    logic [W-1:0] hd;
    logic [A-1:0] hi, ha;
    logic hl;
    while (acc < L && n < 400) begin
      if (held) begin
        chk("hold_data", 64'(outData), 64'(hd));
        chk("hold_idx",  64'(outIdx),  64'(hi));
        chk("hold_last", 64'(outLast), 64'(hl));
        chk("hold_adr",  64'(lutAdr),  64'(ha));
      end
      if (tput && n > 0) chk("tput_vld", 64'(outValid), 64'd1);
      outReady = (int'($urandom_range(0, 99)) < rdy_pct);
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (outValid && outReady) begin
        chk("word_idx",  64'(outIdx),  64'(acc));
        chk("word_data", 64'(outData), 64'(lut10[acc]));
        chk("word_last", 64'(outLast), 64'(acc == L - 1));
        acc++;
      end
      held = outValid && !outReady;
      hd = outData; hi = outIdx; hl = outLast; ha = lutAdr;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    outReady = 1'b0;
    chk("pass_count", 64'(acc), 64'(L));
    chk("done_hi",    64'(done),     64'd1);
    chk("done_busy",  64'(busy),     64'd0);
    chk("done_vld",   64'(outValid), 64'd0);
    if (!chain) begin
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd0);
    end
  endtask

  task automatic pass10(input int rdy_pct, input bit poke, input bit tput, input bit chain);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 64'(busy),     64'd1);
    chk("start_adr",  64'(lutAdr),   64'd0);
    chk("start_vld",  64'(outValid), 64'd0);
    drain(0, rdy_pct, poke, tput, chain);
  endtask

  task automatic wait_idx(input int k);
    int n = 0;
    bit found = 1'b0;
    while (n < 60 && !found) begin
      if (outValid && outIdx == k[A-1:0]) found = 1'b1;
      else begin
        outReady = 1'b1;
        @(negedge clk);
        n++;
      end
    end
    chk("wait_idx", 64'(found), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc16, n16;
    logic [A-1:0] mx;

    for (int i = 0; i < 16; i++) begin
      lut10[i] = $urandom;
      lut16[i] = $urandom;
    end
    lut10[0] = 32'hF33FF740;
    lut10[1] = 32'hFA06FA28;
    lut10[9] = 32'hF1566C30;

    // reset held with start asserted
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; outReady = 1'b0;
    start16 = 1'b0; abort16 = 1'b0; outReady16 = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rst_idle_busy", 64'(busy), 64'd0);

    // full-rate pass
    pass10(100, 1'b0, 1'b1, 1'b0);

    // backpressure on word 1
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_idx(1);
    outReady = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_data", 64'(outData),  64'hFA06FA28);
      chk("bp_idx",  64'(outIdx),   64'd1);
      chk("bp_vld",  64'(outValid), 64'd1);
      chk("bp_adr",  64'(lutAdr),   64'd2);
    end
    drain(1, 100, 1'b0, 1'b0, 1'b0);

    // random readiness with start pokes during the pass
    pass10(60, 1'b1, 1'b0, 1'b0);
    pass10(35, 1'b1, 1'b0, 1'b0);

    // abort at word 4, then restart from word 0
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_idx(4);
    abort = 1'b1; outReady = 1'b1;
    @(negedge clk);
    abort = 1'b0; outReady = 1'b0;
    chk("abort_vld",  64'(outValid), 64'd0);
    chk("abort_busy", 64'(busy),     64'd0);
    chk("abort_done", 64'(done),     64'd0);
    @(negedge clk);
    chk("abort_done2", 64'(done), 64'd0);
    pass10(100, 1'b0, 1'b0, 1'b0);

    // start together with abort while idle
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 64'(busy),     64'd0);
    chk("sa_vld",  64'(outValid), 64'd0);
    @(negedge clk);
    chk("sa_busy2", 64'(busy), 64'd0);

    // back-to-back passes, second start in the done cycle
    pass10(70, 1'b0, 1'b0, 1'b1);
    pass10(100, 1'b0, 1'b1, 1'b0);

    // abort coinciding with the final accept
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_idx(9);
    chk("al_last", 64'(outLast), 64'd1);
    abort = 1'b1; outReady = 1'b1;
    @(negedge clk);
    abort = 1'b0; outReady = 1'b0;
    chk("al_done", 64'(done),     64'd0);
    chk("al_busy", 64'(busy),     64'd0);
    chk("al_vld",  64'(outValid), 64'd0);
    @(negedge clk);
    chk("al_done2", 64'(done), 64'd0);

    // reset in the middle of a pass
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_idx(6);
    outReady = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("mrst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);

    // full address range build
    start16 = 1'b1; @(negedge clk); start16 = 1'b0;
    acc16 = 0; n16 = 0; mx = '0;
    while (acc16 < L16 && n16 < 100) begin
      if (lutAdr16 > mx) mx = lutAdr16;
      outReady16 = 1'b1;
      if (outValid16) begin
        chk("p16_idx",  64'(outIdx16),  64'(acc16));
        chk("p16_data", 64'(outData16), 64'(lut16[acc16]));
        chk("p16_last", 64'(outLast16), 64'(acc16 == L16 - 1));
        acc16++;
      end
      @(negedge clk);
      n16++;
    end
    outReady16 = 1'b0;
    chk("p16_count", 64'(acc16),      64'(L16));
    chk("p16_maxadr", 64'(mx),        64'd15);
    chk("p16_adr",   64'(lutAdr16),   64'd15);
    chk("p16_done",  64'(done16),     64'd1);
    chk("p16_vld",   64'(outValid16), 64'd0);
    chk("p16_busy",  64'(busy16),     64'd0);
    @(negedge clk);
    chk("p16_pulse", 64'(done16), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
